// File: rtl/mux_ctrl_pkg.sv
// Shared definitions for the round-robin mux controller.
//   NUM_REQ   : number of requesters sharing the 4:1 mux
//   SEL_W     : width of the mux select ({s1,s0})
//   state_t   : controller state encoding
//   onehot2idx: index of the set bit of a one-hot grant vector
package mux_ctrl_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Zero input maps to index 0; callers only use it while a grant is held.
  function automatic logic [SEL_W-1:0] onehot2idx(input logic [NUM_REQ-1:0] oh);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (oh[i]) r = SEL_W'(i);
    return r;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search.
//   req  : request vector
//   last : most recent owner; search order is last+1, last+2, last+3, last
//   idx  : first requesting index in that order (0 when none)
//   any  : at least one request is set
module rr_pick
  import mux_ctrl_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic [SEL_W-1:0]   idx,
  output logic               any
);

  logic             found;
  logic [SEL_W-1:0] cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    any   = |req;
    // The 2-bit add wraps mod 4, so the final step (offset 4) lands on last.
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = last + SEL_W'(i);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin owner of a shared 4:1 mux with bounded hold.
//   clk  : clock
//   rst  : synchronous active-high reset
//   req  : request vector, held high while a requester wants the mux
//   gnt  : registered one-hot grant
//   s1,s0: registered mux select, {s1,s0} = owner index
//   en   : registered mux enable, equals |gnt
//   busy : controller is in the GRANT state
module mux_rr_arbiter
  import mux_ctrl_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               s1,
  output logic               s0,
  output logic               en,
  output logic               busy
);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               en_q, en_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic [SEL_W-1:0]   last_q, last_d;

  logic [SEL_W-1:0]   owner;
  logic [SEL_W-1:0]   pick_base;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_any;

  assign owner = onehot2idx(gnt_q);

  // While granted, searching from the current owner both skips it on a
  // release (its req is low) and falls back to it on a lone expiry.
  assign pick_base = (state_q == ST_GRANT) ? owner : last_q;

  rr_pick u_pick (
    .req  (req),
    .last (pick_base),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      en_q    <= 1'b0;
      hold_q  <= '0;
      last_q  <= SEL_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    en_d    = en_q;
    hold_d  = hold_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d         = ST_GRANT;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          sel_d           = pick_idx;
          en_d            = 1'b1;
          hold_d          = '0;
        end
      end
      ST_GRANT: begin
        if (!req[owner] || hold_q == CNT_W'(MAX_HOLD - 1)) begin
          // Release or expiry: hand off (possibly back to the owner itself).
          last_d = owner;
          hold_d = '0;
          if (pick_any) begin
            gnt_d           = '0;
            gnt_d[pick_idx] = 1'b1;
            sel_d           = pick_idx;
            en_d            = 1'b1;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            en_d    = 1'b0;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign gnt  = gnt_q;
  assign s1   = sel_q[1];
  assign s0   = sel_q[0];
  assign en   = en_q;
  assign busy = (state_q == ST_GRANT);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench: two arbiters (MAX_HOLD=4 and MAX_HOLD=1) share the
// same stimulus and are compared each cycle against an integer-level model.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt [2];
  logic       s1 [2], s0 [2], en [2], busy [2];

  int n_chk = 0;
  int n_err = 0;

  // Model state per instance: owner (-1 = none), last owner, hold count, select.
  int lim    [2] = '{4, 1};
  int m_own  [2];
  int m_last [2];
  int m_hold [2];
  int m_sel  [2];

  always #5 clk = ~clk;

  mux_rr_arbiter #(.MAX_HOLD(4), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt[0]),
    .s1(s1[0]), .s0(s0[0]), .en(en[0]), .busy(busy[0]));

  mux_rr_arbiter #(.MAX_HOLD(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt[1]),
    .s1(s1[1]), .s0(s0[1]), .en(en[1]), .busy(busy[1]));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int base);
    for (int d = 1; d <= 4; d++)
      if (r[(base + d) % 4]) return (base + d) % 4;
    return -1;
  endfunction

  task automatic model(input int u, input logic [3:0] r, input logic rs);
    int p;
    if (rs) begin
      m_own[u] = -1; m_last[u] = 3; m_hold[u] = 0; m_sel[u] = 0;
    end else if (m_own[u] < 0) begin
      p = pick(r, m_last[u]);
      if (p >= 0) begin m_own[u] = p; m_sel[u] = p; m_hold[u] = 0; end
    end else if (!r[m_own[u]] || m_hold[u] == lim[u] - 1) begin
      m_last[u] = m_own[u];
      m_hold[u] = 0;
      p = pick(r, m_own[u]);
      m_own[u] = p;
      if (p >= 0) m_sel[u] = p;
    end else begin
      m_hold[u]++;
    end
  endtask

  // One clock: apply inputs, advance the model, check #1 after the edge.
  task automatic cyc(input logic [3:0] r, input logic rs);
    logic [3:0] eg;
    req = r;
    rst = rs;
    @(posedge clk);
    for (int u = 0; u < 2; u++) model(u, r, rs);
    #1;
    for (int u = 0; u < 2; u++) begin
      eg = (m_own[u] < 0) ? 4'b0000 : 4'(1 << m_own[u]);
      chk($sformatf("gnt%0d", u),  {4'b0, gnt[u]}, {4'b0, eg});
      chk($sformatf("sel%0d", u),  {6'b0, s1[u], s0[u]}, 8'(m_sel[u]));
      chk($sformatf("en%0d", u),   {7'b0, en[u]}, {7'b0, m_own[u] >= 0});
      chk($sformatf("busy%0d", u), {7'b0, busy[u]}, {7'b0, m_own[u] >= 0});
    end
  endtask

  initial begin
    logic [3:0] r;
    req = 4'b0;
    rst = 1'b1;
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b1);
    chk("rst_gnt", {4'b0, gnt[0]}, 8'h00);

    // Single requester, then drop.
    cyc(4'b0001, 1'b0);
    chk("single_gnt", {4'b0, gnt[0]}, 8'h01);
    chk("single_busy", {7'b0, busy[0]}, 8'h01);
    cyc(4'b0000, 1'b0);
    chk("drop_en", {7'b0, en[0]}, 8'h00);
    chk("drop_sel", {6'b0, s1[0], s0[0]}, 8'h00);

    // All requesting: rotation every 4 cycles on dut0, every cycle on dut1.
    cyc(4'b0000, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cyc(4'b1111, 1'b0);
      chk("rot_gnt", {4'b0, gnt[0]}, 8'(1 << ((i / 4) % 4)));
      chk("rot1_gnt", {4'b0, gnt[1]}, 8'(1 << (i % 4)));
    end

    // Lone requester renewal.
    cyc(4'b0000, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cyc(4'b0100, 1'b0);
      chk("renew_gnt", {4'b0, gnt[0]}, 8'h04);
    end

    // Owner 0 holding, req[3] raised at hold_cnt=1: no preemption until expiry.
    cyc(4'b0000, 1'b1);
    cyc(4'b0001, 1'b0);
    cyc(4'b0001, 1'b0);
    cyc(4'b1001, 1'b0);
    chk("nopre_gnt", {4'b0, gnt[0]}, 8'h01);
    cyc(4'b1001, 1'b0);
    cyc(4'b1001, 1'b0);
    chk("expiry_gnt", {4'b0, gnt[0]}, 8'h08);
    chk("expiry_sel", {6'b0, s1[0], s0[0]}, 8'h03);

    // Owner 2 releases while req[1] pending: direct handoff.
    cyc(4'b0000, 1'b1);
    cyc(4'b0100, 1'b0);
    cyc(4'b0110, 1'b0);
    cyc(4'b0010, 1'b0);
    chk("handoff_gnt", {4'b0, gnt[0]}, 8'h02);
    chk("handoff_en", {7'b0, en[0]}, 8'h01);

    // Reset mid-grant.
    cyc(4'b1111, 1'b0);
    cyc(4'b1111, 1'b0);
    cyc(4'b1111, 1'b1);
    chk("midrst_gnt", {4'b0, gnt[0]}, 8'h00);
    cyc(4'b1111, 1'b0);
    chk("postrst_gnt", {4'b0, gnt[0]}, 8'h01);

    // Randomized sticky requests with occasional reset.
    r = 4'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      cyc(r, $urandom_range(0, 63) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
